frenzy_rom_loader: RTL and testbench
====================================

Name: frenzy_rom_loader

Overview:
- Sits between the HPS download interface and the berzerk core, directly upstream of the core's ROM download port.
- Registers the ioctl byte stream and decodes it into three ROM regions: program ROM, sound/speech ROM and colour PROM.
- Emits region-local addresses and one-hot write strobes.
- Holds the core in reset during download and for a fixed settle time afterwards, then reports ROM ready plus byte-count/overrun status.

Parameters:
- ADDR_W, 16, width of incoming download address and region-local output address.
- PRG_SIZE, 16'h4000, bytes in program ROM region (base 0).
- SND_SIZE, 16'h1000, bytes in sound ROM region (base PRG_SIZE).
- COL_SIZE, 16'h0020, bytes in colour PROM region (base PRG_SIZE+SND_SIZE).
- HOLD_CYCLES, 64, clk_sys cycles core reset stays asserted after download ends (min 1).

Ports:
- clk_sys, in, 1, system clock (40 MHz).
- reset_n, in, 1, asynchronous active-low reset.
- ioctl_download, in, 1, download active level from hps_io.
- ioctl_wr, in, 1, byte-valid strobe, single-cycle.
- ioctl_addr, in, ADDR_W, byte address within download.
- ioctl_dout, in, 8, byte data.
- dn_addr, out, ADDR_W, region-local address (ioctl_addr minus region base).
- dn_data, out, 8, registered byte.
- prg_wr, out, 1, write strobe for program ROM.
- snd_wr, out, 1, write strobe for sound ROM.
- col_wr, out, 1, write strobe for colour PROM.
- core_reset, out, 1, active-high reset to core.
- rom_ready, out, 1, high once a full, non-overrun load has completed and settled.
- load_overrun, out, 1, sticky; a write addressed beyond PRG_SIZE+SND_SIZE+COL_SIZE-1.
- byte_count, out, ADDR_W+1, number of accepted in-range writes in the current/last download.
- checksum, out, 16, additive sum of accepted bytes (present only with ROM_CHECKSUM_EN).

Behaviour:
- Reset values: outputs 0 except core_reset=1. State IDLE.
- States:
  - IDLE: core_reset=1, rom_ready=0. ioctl_download=1 → LOAD, which clears byte_count, load_overrun and checksum on entry.
  - LOAD: core_reset=1. Each ioctl_wr is decoded and registered. ioctl_download=0 → HOLD, hold counter loaded with HOLD_CYCLES-1.
  - HOLD: core_reset=1; counter decrements each cycle. At 0 → READY. ioctl_download=1 in HOLD → LOAD (fresh clear).
  - READY: core_reset=0. rom_ready=1 iff byte_count==PRG_SIZE+SND_SIZE+COL_SIZE and load_overrun=0; otherwise rom_ready=0 and core_reset stays 1. ioctl_download=1 → LOAD, and core_reset asserts in the same cycle the state is registered.
- Write path:
  - Latency is 1 cycle: the ioctl_wr in cycle N produces the strobe, dn_addr and dn_data in cycle N+1.
  - Strobes are one-hot, asserted 1 cycle, and never asserted outside LOAD.
- Decode:
  - addr<PRG_SIZE → prg_wr, dn_addr=addr.
  - Next SND_SIZE bytes → snd_wr, dn_addr=addr-PRG_SIZE.
  - Next COL_SIZE bytes → col_wr, dn_addr offset likewise.
  - Anything beyond → no strobe, load_overrun=1, byte_count unchanged.
- Boundaries:
  - Exact region edges decode to the higher region; e.g. addr=PRG_SIZE → snd_wr with dn_addr=0.
  - byte_count saturates at 2^(ADDR_W+1)-1.
  - Duplicate addresses count each time.
  - ioctl_wr outside LOAD is ignored.
  - ioctl_wr in the same cycle ioctl_download falls is accepted.
- reset_n low mid-download: immediate return to IDLE; all status cleared; core_reset=1.

Optional Feature:
- ROM_CHECKSUM_EN defined:
  - checksum port exists; 16-bit wrap-around sum of every accepted in-range byte, updated with the strobe cycle; cleared on LOAD entry.
  - rom_ready additionally requires checksum==EXPECT_SUM, a 16-bit parameter added under the macro with default 16'h0000 meaning "don't check".
- Undefined: checksum port and logic absent; rom_ready depends on count/overrun only.

Test Plan:
- Reset with reset_n=0 → core_reset=1, rom_ready=0, strobes 0, byte_count=0, state IDLE.
- Full download, bytes 0..0x501F sequential, then download falls → prg_wr 0x4000 times, snd_wr 0x1000, col_wr 0x20; after 64 cycles core_reset=0, rom_ready=1, byte_count=0x5020.
- Edge decode: addr 0x3FFF, 0x4000, 0x4FFF, 0x5000 → prg_wr@0x3FFF, snd_wr@0x000, snd_wr@0xFFF, col_wr@0x00, each one cycle after ioctl_wr.
- Overrun: full load plus one write at 0x5020 → no strobe, load_overrun=1, rom_ready=0, core_reset stays 1.
- Re-download from READY at cycle 30 of the next HOLD → core_reset reasserts; status cleared; a second full load yields rom_ready=1 again.
- ROM_CHECKSUM_EN: load bytes all 0x01 with EXPECT_SUM=16'h5020 → rom_ready=1; with EXPECT_SUM=16'h5021 → rom_ready=0.

Source files
------------

// File: rtl/frenzy_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : frenzy_rom_loader
// Purpose  : Decodes the HPS ioctl download byte stream into the berzerk
//            core's ROM regions. These are program ROM, sound/speech ROM and
//            colour PROM. The block also sequences the core reset around a
//            download.
//            Each accepted byte is registered. It is presented with a
//            region-local address and a one-hot write strobe one cycle after
//            its ioctl_wr. The core is held in reset while the download runs
//            and for HOLD_CYCLES clocks after it ends. After that the block
//            reports whether the load was complete and free of overrun.
// Config   : define ROM_CHECKSUM_EN to add the checksum output and the
//            EXPECT_SUM check on rom_ready.
// Ports    : clk_sys, reset_n (async, active low)
//            ioctl_download/ioctl_wr/ioctl_addr/ioctl_dout - download input
//            dn_addr/dn_data/prg_wr/snd_wr/col_wr         - ROM write port
//            core_reset/rom_ready/load_overrun/byte_count - status
//            checksum (ROM_CHECKSUM_EN only)              - sum of bytes
// Revision : 1.0 - initial release
// ============================================================================
module frenzy_rom_loader #(
   parameter int          ADDR_W      = 16,
   parameter int unsigned PRG_SIZE    = 'h4000,
   parameter int unsigned SND_SIZE    = 'h1000,
   parameter int unsigned COL_SIZE    = 'h0020,
   parameter int          HOLD_CYCLES = 64
`ifdef ROM_CHECKSUM_EN
   ,
   parameter logic [15:0] EXPECT_SUM  = 16'h0000
`endif
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic              prg_wr,
   output logic              snd_wr,
   output logic              col_wr,
   output logic              core_reset,
   output logic              rom_ready,
   output logic              load_overrun,
   output logic [ADDR_W:0]   byte_count
`ifdef ROM_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   // Region limits in ADDR_W+1 bits so the end of the last region can be
   // compared without wrapping.
   localparam int unsigned     TOTAL_SIZE = PRG_SIZE + SND_SIZE + COL_SIZE;
   localparam logic [ADDR_W:0] SND_BASE_X = (ADDR_W+1)'(PRG_SIZE);
   localparam logic [ADDR_W:0] COL_BASE_X = (ADDR_W+1)'(PRG_SIZE + SND_SIZE);
   localparam logic [ADDR_W:0] END_X      = (ADDR_W+1)'(TOTAL_SIZE);
   localparam logic [ADDR_W-1:0] SND_BASE = ADDR_W'(PRG_SIZE);
   localparam logic [ADDR_W-1:0] COL_BASE = ADDR_W'(PRG_SIZE + SND_SIZE);

   localparam int          HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      HOLD  = 2'd2,
      READY = 2'd3
   } state_t;

   state_t              state;
   logic [HOLD_W-1:0]   hold_cnt;

   logic [ADDR_W:0]     addr_x;
   logic                hit_prg;
   logic                hit_snd;
   logic                hit_col;
   logic                hit_any;
   logic [ADDR_W-1:0]   local_addr;
   logic                sum_ok;
   logic                ready_ok;

   // Region decode. Each compare is a strict "less than", so an address that
   // sits exactly on a region edge falls into the higher region.
   always_comb begin
      addr_x     = {1'b0, ioctl_addr};
      hit_prg    = 1'b0;
      hit_snd    = 1'b0;
      hit_col    = 1'b0;
      local_addr = ioctl_addr;
      if (addr_x < SND_BASE_X) begin
         hit_prg = 1'b1;
      end else if (addr_x < COL_BASE_X) begin
         hit_snd    = 1'b1;
         local_addr = ioctl_addr - SND_BASE;
      end else if (addr_x < END_X) begin
         hit_col    = 1'b1;
         local_addr = ioctl_addr - COL_BASE;
      end
   end

   assign hit_any = hit_prg | hit_snd | hit_col;

`ifdef ROM_CHECKSUM_EN
   // An EXPECT_SUM of zero disables the checksum check.
   assign sum_ok = (EXPECT_SUM == 16'h0000) || (checksum == EXPECT_SUM);
`else
   assign sum_ok = 1'b1;
`endif

   assign ready_ok = (byte_count == END_X) && !load_overrun && sum_ok;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         hold_cnt     <= '0;
         dn_addr      <= '0;
         dn_data      <= '0;
         prg_wr       <= 1'b0;
         snd_wr       <= 1'b0;
         col_wr       <= 1'b0;
         core_reset   <= 1'b1;
         rom_ready    <= 1'b0;
         load_overrun <= 1'b0;
         byte_count   <= '0;
`ifdef ROM_CHECKSUM_EN
         checksum     <= 16'h0000;
`endif
      end else begin
         // Strobes default low so each one lasts a single cycle.
         prg_wr <= 1'b0;
         snd_wr <= 1'b0;
         col_wr <= 1'b0;

         case (state)
            IDLE: begin
               core_reset <= 1'b1;
               rom_ready  <= 1'b0;
               if (ioctl_download) begin
                  state        <= LOAD;
                  byte_count   <= '0;
                  load_overrun <= 1'b0;
`ifdef ROM_CHECKSUM_EN
                  checksum     <= 16'h0000;
`endif
               end
            end

            LOAD: begin
               core_reset <= 1'b1;
               rom_ready  <= 1'b0;
               // A write that arrives in the cycle the download drops is
               // still taken, because the state is LOAD in that cycle.
               if (ioctl_wr) begin
                  if (hit_any) begin
                     prg_wr  <= hit_prg;
                     snd_wr  <= hit_snd;
                     col_wr  <= hit_col;
                     dn_addr <= local_addr;
                     dn_data <= ioctl_dout;
                     if (byte_count != '1) begin
                        byte_count <= byte_count + (ADDR_W+1)'(1);
                     end
`ifdef ROM_CHECKSUM_EN
                     checksum <= checksum + {8'h00, ioctl_dout};
`endif
                  end else begin
                     load_overrun <= 1'b1;
                  end
               end
               if (!ioctl_download) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_LOAD;
               end
            end

            HOLD: begin
               core_reset <= 1'b1;
               rom_ready  <= 1'b0;
               if (ioctl_download) begin
                  state        <= LOAD;
                  byte_count   <= '0;
                  load_overrun <= 1'b0;
`ifdef ROM_CHECKSUM_EN
                  checksum     <= 16'h0000;
`endif
               end else if (hold_cnt == '0) begin
                  // A short or overrun load keeps the core in reset.
                  state      <= READY;
                  rom_ready  <= ready_ok;
                  core_reset <= !ready_ok;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end

            READY: begin
               if (ioctl_download) begin
                  state        <= LOAD;
                  core_reset   <= 1'b1;
                  rom_ready    <= 1'b0;
                  byte_count   <= '0;
                  load_overrun <= 1'b0;
`ifdef ROM_CHECKSUM_EN
                  checksum     <= 16'h0000;
`endif
               end
            end

            default: begin
               state      <= IDLE;
               core_reset <= 1'b1;
               rom_ready  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frenzy_rom_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_frenzy_rom_loader
// Purpose  : Self-checking bench for frenzy_rom_loader. It uses a scoreboard
//            of expected strobe/addr/data/cycle plus directed status checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frenzy_rom_loader;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [15:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        prg_wr, snd_wr, col_wr;
   logic        core_reset, rom_ready, load_overrun;
   logic [16:0] byte_count;
`ifdef ROM_CHECKSUM_EN
   logic [15:0] checksum;
   logic [15:0] c_addr, d_addr, c_sum, d_sum;
   logic [7:0]  c_data, d_data;
   logic        c_prg, c_snd, c_col, c_rst, c_rdy, c_ovr;
   logic        d_prg, d_snd, d_col, d_rst, d_rdy, d_ovr;
   logic [16:0] c_cnt, d_cnt;
`endif

   always #5 clk_sys = ~clk_sys;

   frenzy_rom_loader dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .dn_addr(dn_addr), .dn_data(dn_data),
      .prg_wr(prg_wr), .snd_wr(snd_wr), .col_wr(col_wr),
      .core_reset(core_reset), .rom_ready(rom_ready),
      .load_overrun(load_overrun), .byte_count(byte_count)
`ifdef ROM_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

`ifdef ROM_CHECKSUM_EN
   frenzy_rom_loader #(.EXPECT_SUM(16'h5020)) dut_c (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .dn_addr(c_addr), .dn_data(c_data),
      .prg_wr(c_prg), .snd_wr(c_snd), .col_wr(c_col),
      .core_reset(c_rst), .rom_ready(c_rdy),
      .load_overrun(c_ovr), .byte_count(c_cnt), .checksum(c_sum)
   );
   frenzy_rom_loader #(.EXPECT_SUM(16'h5021)) dut_d (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .dn_addr(d_addr), .dn_data(d_data),
      .prg_wr(d_prg), .snd_wr(d_snd), .col_wr(d_col),
      .core_reset(d_rst), .rom_ready(d_rdy),
      .load_overrun(d_ovr), .byte_count(d_cnt), .checksum(d_sum)
   );
`endif

   typedef struct packed {
      logic [2:0]  region;   // {prg, snd, col}
      logic [15:0] addr;
      logic [7:0]  data;
      logic [31:0] cyc;
   } exp_t;

   exp_t        sb[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] cyc         = 0;
   int          n_prg = 0, n_snd = 0, n_col = 0;
   int          s_prg, s_snd, s_col;

   localparam int TOTAL = 'h5020;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Compare any strobe against the scoreboard head.
   task automatic monitor();
      logic [2:0] s;
      exp_t       e;
      s = {prg_wr, snd_wr, col_wr};
      if (s !== 3'b000) begin
         if (prg_wr === 1'b1) n_prg++;
         if (snd_wr === 1'b1) n_snd++;
         if (col_wr === 1'b1) n_col++;
         if (sb.size() == 0) begin
            chk("unexpected_strobe", {29'd0, s}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("strobe", {29'd0, s}, {29'd0, e.region});
            chk("dn_addr", {16'd0, dn_addr}, {16'd0, e.addr});
            chk("dn_data", {24'd0, dn_data}, {24'd0, e.data});
            chk("latency", cyc, e.cyc);
         end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk("missing_strobe", 32'd0, {29'd0, e.region});
      end
   endtask

   // Inputs are driven 1 ns after the rising edge. Outputs are checked on
   // the falling edge.
   task automatic tick();
      @(negedge clk_sys);
      monitor();
      @(posedge clk_sys);
      cyc++;
      #1;
   endtask

   // Independent memory map: prg 0..3FFF, snd 4000..4FFF, col 5000..501F.
   task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
      exp_t e;
      e.data = d;
      e.cyc  = cyc + 1;
      if (a < 16'h4000) begin
         e.region = 3'b100; e.addr = a; sb.push_back(e);
      end else if (a < 16'h5000) begin
         e.region = 3'b010; e.addr = a - 16'h4000; sb.push_back(e);
      end else if (a < 16'h5020) begin
         e.region = 3'b001; e.addr = a - 16'h5000; sb.push_back(e);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit fall);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (fall) ioctl_download = 1'b0;
      push_exp(a, d);
      tick();
      ioctl_wr = 1'b0;
   endtask

   // A write that must be ignored, so nothing is pushed to the scoreboard.
   task automatic stray_wr(input logic [15:0] a);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = 8'h77;
      tick();
      ioctl_wr = 1'b0;
   endtask

   function automatic logic [7:0] data_of(input int mode, input logic [15:0] a);
      case (mode)
         0:       return a[7:0] ^ a[15:8];
         1:       return ~a[7:0];
         default: return 8'h01;
      endcase
   endfunction

   task automatic start_dl(input string tag);
      ioctl_download = 1'b1;
      tick();
      chk({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
      chk({tag, "_rom_ready"},  {31'd0, rom_ready},  32'd0);
      chk({tag, "_count_clr"},  {15'd0, byte_count}, 32'd0);
      chk({tag, "_ovr_clr"},    {31'd0, load_overrun}, 32'd0);
   endtask

   task automatic load_full(input int mode, input bit fall_last);
      for (int i = 0; i < TOTAL; i++) begin
         wr(16'(i), data_of(mode, 16'(i)), fall_last && (i == TOTAL - 1));
      end
   endtask

   // Called one cycle after the download falls, which is the first HOLD cycle.
   task automatic finish_hold(input string tag, input bit exp_ready);
      repeat (63) tick();
      chk({tag, "_hold_core_reset"}, {31'd0, core_reset}, 32'd1);
      chk({tag, "_hold_rom_ready"},  {31'd0, rom_ready},  32'd0);
      tick();
      chk({tag, "_core_reset"}, {31'd0, core_reset}, {31'd0, !exp_ready});
      chk({tag, "_rom_ready"},  {31'd0, rom_ready},  {31'd0, exp_ready});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = '0;
      ioctl_dout     = '0;
      repeat (2) @(posedge clk_sys);
      #1;
      chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
      chk("rst_rom_ready",  {31'd0, rom_ready},  32'd0);
      chk("rst_strobes",    {29'd0, prg_wr, snd_wr, col_wr}, 32'd0);
      chk("rst_count",      {15'd0, byte_count}, 32'd0);
      chk("rst_overrun",    {31'd0, load_overrun}, 32'd0);
      chk("rst_dn_addr",    {16'd0, dn_addr}, 32'd0);
      reset_n = 1'b1;
      tick();

      // A write in IDLE is ignored.
      stray_wr(16'h0000);
      tick();
      chk("idle_wr_count", {15'd0, byte_count}, 32'd0);

      // Load 1: full sequential load that is expected to become ready.
      s_prg = n_prg; s_snd = n_snd; s_col = n_col;
      start_dl("l1_start");
      load_full(0, 1'b1);
      chk("l1_overrun", {31'd0, load_overrun}, 32'd0);
      finish_hold("l1", 1'b1);
      chk("l1_count", {15'd0, byte_count}, 32'h5020);
      chk("l1_n_prg", n_prg - s_prg, 32'h4000);
      chk("l1_n_snd", n_snd - s_snd, 32'h1000);
      chk("l1_n_col", n_col - s_col, 32'h0020);

      // A write in READY is ignored.
      stray_wr(16'h0100);
      tick();
      chk("ready_wr_count", {15'd0, byte_count}, 32'h5020);
      chk("ready_wr_ready", {31'd0, rom_ready}, 32'd1);

      // Load 2: re-download from READY and decode the region edges.
      start_dl("l2_start");
      wr(16'h3FFF, 8'hA1, 1'b0);
      wr(16'h4000, 8'hB2, 1'b0);
      wr(16'h4FFF, 8'hC3, 1'b0);
      wr(16'h5000, 8'hD4, 1'b1);
      stray_wr(16'h0200);
      tick();
      chk("l2_count", {15'd0, byte_count}, 32'd4);
      chk("l2_overrun", {31'd0, load_overrun}, 32'd0);
      repeat (27) tick();
      chk("l2_hold_core_reset", {31'd0, core_reset}, 32'd1);
      start_dl("l2_redl");
      wr(16'h0010, 8'h5A, 1'b0);
      tick();
      chk("l2_redl_count", {15'd0, byte_count}, 32'd1);

      // Reset in the middle of a download.
      reset_n = 1'b0;
      #1;
      chk("midrst_core_reset", {31'd0, core_reset}, 32'd1);
      chk("midrst_count",      {15'd0, byte_count}, 32'd0);
      chk("midrst_ready",      {31'd0, rom_ready}, 32'd0);
      chk("midrst_overrun",    {31'd0, load_overrun}, 32'd0);
      ioctl_download = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      // Load 3: a full load plus one out-of-range byte.
      start_dl("l3_start");
      load_full(1, 1'b0);
      wr(16'h5020, 8'hEE, 1'b1);
      chk("l3_overrun", {31'd0, load_overrun}, 32'd1);
      finish_hold("l3", 1'b0);
      chk("l3_count", {15'd0, byte_count}, 32'h5020);
      chk("l3_overrun_sticky", {31'd0, load_overrun}, 32'd1);

      // Load 4: reload from the failed READY state with every byte 0x01.
      start_dl("l4_start");
      load_full(2, 1'b1);
      finish_hold("l4", 1'b1);
      chk("l4_count", {15'd0, byte_count}, 32'h5020);
`ifdef ROM_CHECKSUM_EN
      chk("l4_checksum", {16'd0, checksum}, 32'h5020);
      chk("l4_sum_match_ready", {31'd0, c_rdy}, 32'd1);
      chk("l4_sum_miss_ready",  {31'd0, d_rdy}, 32'd0);
      chk("l4_sum_miss_reset",  {31'd0, d_rst}, 32'd1);
`endif

      tick();
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
